// File: rtl/diff_wb_pkg.sv
// Shared types and constants for the diff_writeback stage.
// The clamp-event counter width lives here so the counter and its port agree.
package diff_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROC  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  localparam int SAT_CNT_W = 16;

endpackage : diff_wb_pkg

// File: rtl/diff_writeback_round_clamp.sv
// round_clamp: purely combinational round-half-up arithmetic right shift
// followed by a signed clamp to OUT_WIDTH. The intermediate is one bit wider
// than the input so the rounding add can never wrap.
module round_clamp #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 4
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  sat
);

  localparam int WW = DATA_WIDTH + 1;

  // Half an LSB of the shifted result; (1<<SHIFT)>>1 is zero when SHIFT==0,
  // which makes the no-shift build a plain pass-through.
  localparam logic signed [WW-1:0] RND = (WW'(1) << SHIFT) >> 1;

  // Output range limits expressed in the widened domain.
  localparam logic signed [WW-1:0] MAX_POS =
    {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_NEG =
    {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [WW-1:0] widened;
  logic signed [WW-1:0] rounded;
  logic signed [WW-1:0] shifted;

  // Sign-extend, add the rounding constant, shift, then clamp.
  // NOTE: every output gets a default before any branch, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    widened = $signed({din[DATA_WIDTH-1], din});
    rounded = widened + RND;
    shifted = rounded >>> SHIFT;
    dout    = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (shifted > MAX_POS) begin
      dout = MAX_POS[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_NEG) begin
      dout = MIN_NEG[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule : round_clamp

// File: rtl/diff_writeback.sv
// diff_writeback: pops one signed difference from the subtractor, rounds and
// clamps it to OUT_WIDTH, and pushes it into the output FIFO.
// Sequence per word: S_IDLE (pop) -> S_PROC (compute) -> S_WRITE (push).
// Optional feature: define DIFF_WB_SAT_COUNT_EN to build the clamp-event
// counter on sat_count; otherwise sat_count is tied to zero.
module diff_writeback
  import diff_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_complete,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [OUT_WIDTH-1:0]  out_din,
  output logic                  sat_flag,
  output logic [SAT_CNT_W-1:0]  sat_count
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [OUT_WIDTH-1:0]  out_din_q, out_din_d;
  logic                  sat_flag_q, sat_flag_d;

  logic [OUT_WIDTH-1:0]  rc_dout;
  logic                  rc_sat;

  round_clamp #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_round_clamp (
    .din  (hold_q),
    .dout (rc_dout),
    .sat  (rc_sat)
  );

  // State register.
  // NOTE: non-blocking assignments so every flop samples pre-edge values,
  // independent of the order in which the always blocks are evaluated.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one pop, one compute cycle, then wait for FIFO space.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_rd_en)  state_d = S_PROC;
      S_PROC:                 state_d = S_WRITE;
      S_WRITE: if (out_wr_en) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake strobes; both are masked during reset so the reset cycle
  // neither consumes an upstream result nor pushes a stale word.
  always_comb begin
    in_rd_en  = !reset && (state_q == S_IDLE)  && in_complete;
    out_wr_en = !reset && (state_q == S_WRITE) && !out_full;
  end

  // Datapath next values: capture on pop, latch the result in S_PROC, and
  // otherwise hold so the word stays stable while the FIFO is full.
  always_comb begin
    hold_d     = hold_q;
    out_din_d  = out_din_q;
    sat_flag_d = sat_flag_q;
    if (in_rd_en) hold_d = in_data;
    if (state_q == S_PROC) begin
      out_din_d  = rc_dout;
      sat_flag_d = rc_sat;
    end
  end

  // Datapath registers; reset discards any held or unwritten word.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q     <= '0;
      out_din_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      out_din_q  <= out_din_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign out_din  = out_din_q;
  assign sat_flag = sat_flag_q;

`ifdef DIFF_WB_SAT_COUNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Count pushes of clamped words, sticking at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (out_wr_en && sat_flag_q && (sat_cnt_q != {SAT_CNT_W{1'b1}}))
      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
  end

  // Clamp-event counter register.
  always_ff @(posedge clock) begin
    if (reset) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule : diff_writeback
